// File: rtl/gen2_pkg.sv
// Shared Gen2 forward-link definitions: Query framing constants, receiver
// states, Query field arrival indices and the serial CRC-5 step.
package gen2_pkg;

  localparam logic [3:0]  QUERY_CMD   = 4'b1000;
  localparam int unsigned QUERY_LEN   = 22;
  localparam logic [4:0]  CRC5_PRESET = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DISCARD
  } rx_state_t;

  // Arrival index (1-based, MSB of command first) of each field's first bit
  localparam int unsigned DR_IDX      = 5;
  localparam int unsigned M_IDX       = 6;
  localparam int unsigned TREXT_IDX   = 8;
  localparam int unsigned SEL_IDX     = 9;
  localparam int unsigned SESSION_IDX = 11;
  localparam int unsigned TARGET_IDX  = 13;
  localparam int unsigned Q_IDX       = 14;

  // x^5 + x^3 + 1, one input bit per call
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
    logic f;
    f = b ^ crc[4];
    return {crc[3], crc[2] ^ f, crc[1], crc[0], f};
  endfunction

endpackage

// File: rtl/crc5_serial.sv
// Bit-serial CRC-5 register (x^5+x^3+1); shared form with the tag CRC-5 checker.
module crc5_serial #(
  parameter logic [4:0] PRESET = gen2_pkg::CRC5_PRESET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       en,
  input  logic       bit_in,
  output logic [4:0] crc
);
  import gen2_pkg::*;

  // init with en folds the first bit of a new packet into the preset
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= PRESET;
    end else if (init) begin
      crc <= en ? crc5_step(PRESET, bit_in) : PRESET;
    end else if (en) begin
      crc <= crc5_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/query_rx.sv
// Gen2 tag-side Query receiver: frames a 22-bit Query from decoded bits,
// checks CRC-5 and length, and latches the Query fields on a good packet.
module query_rx #(
  parameter int unsigned QUERY_LEN   = gen2_pkg::QUERY_LEN,
  parameter logic [4:0]  CRC5_PRESET = gen2_pkg::CRC5_PRESET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_start,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       pkt_end,
  output logic       busy,
  output logic       query_valid,
  output logic       crc_err,
  output logic       len_err,
  output logic       dr,
  output logic       trext,
  output logic       target,
  output logic [1:0] m,
  output logic [1:0] sel,
  output logic [1:0] session,
  output logic [3:0] q
);
  import gen2_pkg::*;

  localparam logic [4:0] LEN  = 5'(QUERY_LEN);
  localparam logic [4:0] OVER = 5'(QUERY_LEN + 1);

  rx_state_t            state, state_n;
  logic [4:0]           cnt, cnt_n, base_cnt;
  logic [QUERY_LEN-1:0] sr, sr_n, base_sr;
  logic [4:0]           crc, crc_base, crc_n;
  logic                 over, over_n;
  logic                 take, prefix_bad;
  logic                 qv_n, ce_n, le_n;

  crc5_serial #(.PRESET(CRC5_PRESET)) u_crc (
    .clk    (clk),
    .reset  (reset),
    .init   (pkt_start),
    .en     (take),
    .bit_in (bit_in),
    .crc    (crc)
  );

  assign busy = (state != ST_IDLE);

  // Count, shift and CRC are evaluated as "next" values so a bit arriving
  // with pkt_start or pkt_end is part of the packet it belongs to.
  always_comb begin
    take     = bit_valid & (pkt_start | (state == ST_RECV));
    base_cnt = pkt_start ? '0 : cnt;
    base_sr  = pkt_start ? '0 : sr;
    crc_base = pkt_start ? CRC5_PRESET : crc;
    cnt_n    = base_cnt;
    sr_n     = base_sr;
    crc_n    = crc_base;
    if (take) begin
      cnt_n = (base_cnt == '1) ? base_cnt : base_cnt + 5'd1;
      sr_n  = {base_sr[QUERY_LEN-2:0], bit_in};
      crc_n = crc5_step(crc_base, bit_in);
    end
    prefix_bad = (cnt_n == 5'd4) && (sr_n[3:0] != QUERY_CMD);

    state_n = state;
    over_n  = over;
    qv_n    = 1'b0;
    ce_n    = 1'b0;
    le_n    = 1'b0;
    if (pkt_start) begin
      state_n = ST_RECV;
      over_n  = 1'b0;
    end else begin
      case (state)
        ST_RECV: begin
          if (pkt_end) begin
            state_n = ST_IDLE;
            if (cnt_n == LEN) begin
              qv_n = (crc_n == '0);
              ce_n = (crc_n != '0);
            end else if ((cnt_n >= 5'd4) && !prefix_bad) begin
              le_n = 1'b1;
            end
          end else if (cnt_n == OVER) begin
            state_n = ST_DISCARD;
            over_n  = 1'b1;
          end else if (prefix_bad) begin
            state_n = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (pkt_end) begin
            state_n = ST_IDLE;
            le_n    = over;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sr          <= '0;
      over        <= 1'b0;
      query_valid <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      dr          <= 1'b0;
      trext       <= 1'b0;
      target      <= 1'b0;
      m           <= '0;
      sel         <= '0;
      session     <= '0;
      q           <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      over        <= over_n;
      query_valid <= qv_n;
      crc_err     <= ce_n;
      len_err     <= le_n;
      if (qv_n) begin
        dr      <= sr_n[QUERY_LEN-DR_IDX];
        m       <= sr_n[QUERY_LEN-M_IDX -: 2];
        trext   <= sr_n[QUERY_LEN-TREXT_IDX];
        sel     <= sr_n[QUERY_LEN-SEL_IDX -: 2];
        session <= sr_n[QUERY_LEN-SESSION_IDX -: 2];
        target  <= sr_n[QUERY_LEN-TARGET_IDX];
        q       <= sr_n[QUERY_LEN-Q_IDX -: 4];
      end
    end
  end

endmodule
